// File: rtl/instr_prefetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// processor_pkg
// Shared types and constants for the instruction prefetch path.
//   fetch_state_t    : prefetch request FSM states
//   prefetch_entry_t : one buffered instruction plus the address it came from
//   ADDR_W           : instruction address width
//   nextFetchAddr    : sequential address increment, wrapping at 2^ADDR_W
// ---------------------------------------------------------------------------
package processor_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no request outstanding
    FETCH = 2'd1,  // request outstanding, response will be kept
    DRAIN = 2'd2   // request outstanding, response will be dropped
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } prefetch_entry_t;

  // Natural truncation to ADDR_W bits gives the modulo-2^16 wrap.
  function automatic logic [ADDR_W-1:0] nextFetchAddr(input logic [ADDR_W-1:0] addr,
                                                      input int step);
    return addr + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer_if
// Bundles the fetch-stage and instruction-memory signals of the prefetcher.
//   master : prefetcher side (drives MemReq/MemAddr and the Instr* outputs)
//   slave  : environment side (fetch stage + memory)
// Fetch stage : Redirect, RedirectAddr, Take -> ; <- InstrOut, InstrOutAddr, InstrValid
// Memory      : MemReq, MemAddr -> ; <- MemAck, MemRData
// ---------------------------------------------------------------------------
interface instr_prefetch_buffer_if;
  import processor_pkg::*;

  logic              Redirect;
  logic [ADDR_W-1:0] RedirectAddr;
  logic              Take;
  logic [31:0]       InstrOut;
  logic [ADDR_W-1:0] InstrOutAddr;
  logic              InstrValid;
  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemAck;
  logic [31:0]       MemRData;

  modport master (
    input  Redirect, RedirectAddr, Take, MemAck, MemRData,
    output InstrOut, InstrOutAddr, InstrValid, MemReq, MemAddr
  );

  modport slave (
    output Redirect, RedirectAddr, Take, MemAck, MemRData,
    input  InstrOut, InstrOutAddr, InstrValid, MemReq, MemAddr
  );

endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
// Synchronous circular FIFO of prefetch_entry_t.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write din at the tail (ignored when full)
//   pop      : advance the head (ignored when empty, so no underflow)
//   clear    : empty the FIFO; overrides push and pop
//   count    : number of valid entries (0..DEPTH)
//   head     : entry at the head, read straight from storage
// ---------------------------------------------------------------------------
module prefetch_fifo
  import processor_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  prefetch_entry_t din,
  output logic [CNT_W-1:0] count,
  output prefetch_entry_t head
);

  prefetch_entry_t  mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             pushEff;
  logic             popEff;

  assign pushEff = push && (count != CNT_W'(DEPTH));
  assign popEff  = pop  && (count != CNT_W'(0));
  assign head    = mem[rdPtr];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= PTR_W'(0);
      rdPtr <= PTR_W'(0);
      count <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{instr: 32'h0000_0000, addr: {ADDR_W{1'b0}}};
      end
    end else if (clear) begin
      wrPtr <= PTR_W'(0);
      rdPtr <= PTR_W'(0);
      count <= CNT_W'(0);
    end else begin
      if (pushEff) begin
        mem[wrPtr] <= din;
        wrPtr      <= wrPtr + PTR_W'(1);
      end else begin
        wrPtr <= wrPtr;
      end
      if (popEff) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end else begin
        rdPtr <= rdPtr;
      end
      case ({pushEff, popEff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;  // idle, or push+pop balancing out
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
// Sequential instruction prefetcher: keeps up to DEPTH instructions buffered
// ahead of the fetch stage with at most one memory request in flight.
//   Clock, Reset : clock, asynchronous active-high reset
//   bus (master) : Redirect/RedirectAddr/Take from the fetch stage,
//                  InstrOut/InstrOutAddr/InstrValid to the fetch stage,
//                  MemReq/MemAddr to memory, MemAck/MemRData from memory
// Parameters: DEPTH (FIFO entries, power of two >= 2), ADDR_STEP (bytes/word)
// ---------------------------------------------------------------------------
module instr_prefetch_buffer
  import processor_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_STEP = 4
) (
  input logic                     Clock,
  input logic                     Reset,
  instr_prefetch_buffer_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      nextState;
  logic [ADDR_W-1:0] fetchAddr;      // address of the current/next sequential request
  logic [ADDR_W-1:0] fetchAddrNext;
  logic              memReq;
  logic              memReqNext;
  logic [ADDR_W-1:0] memAddr;
  logic [ADDR_W-1:0] memAddrNext;
  logic              fifoPush;
  logic              fifoPop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countAfterPush;
  prefetch_entry_t   head;
  prefetch_entry_t   pushEntry;
  logic              popEff;
  logic              roomNow;
  logic              roomAfterPush;

  // Redirect wins over Take; an empty FIFO ignores Take.
  assign popEff         = bus.Take && !bus.Redirect && (count != CNT_W'(0));
  // Occupancy once the acked word lands; the outstanding slot is freed by the ack.
  assign countAfterPush = count + CNT_W'(1) - (popEff ? CNT_W'(1) : CNT_W'(0));
  assign roomNow        = (count < CNT_W'(DEPTH));
  assign roomAfterPush  = (countAfterPush < CNT_W'(DEPTH));
  assign pushEntry      = '{instr: bus.MemRData, addr: memAddr};

  prefetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .clear (bus.Redirect),
    .din   (pushEntry),
    .count (count),
    .head  (head)
  );

  // FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.Redirect || roomNow) begin
          nextState = FETCH;
        end else begin
          nextState = IDLE;
        end
      end
      FETCH: begin
        if (bus.MemAck) begin
          if (bus.Redirect || roomAfterPush) begin
            nextState = FETCH;
          end else begin
            nextState = IDLE;
          end
        end else if (bus.Redirect) begin
          nextState = DRAIN;
        end else begin
          nextState = FETCH;
        end
      end
      DRAIN: begin
        if (bus.MemAck) begin
          nextState = FETCH;
        end else begin
          nextState = DRAIN;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs: FIFO push/pop and next values of the request registers.
  always_comb begin
    fetchAddrNext = fetchAddr;
    memReqNext    = memReq;
    memAddrNext   = memAddr;
    fifoPush      = 1'b0;
    fifoPop       = popEff;
    case (state)
      IDLE: begin
        if (bus.Redirect) begin
          fetchAddrNext = bus.RedirectAddr;
          memReqNext    = 1'b1;
          memAddrNext   = bus.RedirectAddr;
        end else if (roomNow) begin
          memReqNext  = 1'b1;
          memAddrNext = fetchAddr;
        end else begin
          memReqNext = 1'b0;
        end
      end
      FETCH: begin
        if (bus.MemAck) begin
          if (bus.Redirect) begin
            // Acked word belongs to the old stream: drop it and restart.
            fetchAddrNext = bus.RedirectAddr;
            memReqNext    = 1'b1;
            memAddrNext   = bus.RedirectAddr;
          end else begin
            fifoPush      = 1'b1;
            fetchAddrNext = nextFetchAddr(fetchAddr, ADDR_STEP);
            if (roomAfterPush) begin
              memReqNext  = 1'b1;
              memAddrNext = nextFetchAddr(fetchAddr, ADDR_STEP);
            end else begin
              memReqNext = 1'b0;
            end
          end
        end else if (bus.Redirect) begin
          // Request stays on the bus unchanged; only the restart point moves.
          fetchAddrNext = bus.RedirectAddr;
        end else begin
          fetchAddrNext = fetchAddr;
        end
      end
      DRAIN: begin
        if (bus.MemAck) begin
          // Stale word dropped; launch the redirected request in the same cycle.
          fetchAddrNext = bus.Redirect ? bus.RedirectAddr : fetchAddr;
          memReqNext    = 1'b1;
          memAddrNext   = bus.Redirect ? bus.RedirectAddr : fetchAddr;
        end else if (bus.Redirect) begin
          fetchAddrNext = bus.RedirectAddr;
        end else begin
          fetchAddrNext = fetchAddr;
        end
      end
      default: begin
        memReqNext = 1'b0;
      end
    endcase
  end

  // Request and fetch-address registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fetchAddr <= {ADDR_W{1'b0}};
      memReq    <= 1'b0;
      memAddr   <= {ADDR_W{1'b0}};
    end else begin
      fetchAddr <= fetchAddrNext;
      memReq    <= memReqNext;
      memAddr   <= memAddrNext;
    end
  end

  assign bus.MemReq       = memReq;
  assign bus.MemAddr      = memAddr;
  assign bus.InstrValid   = (count != CNT_W'(0));
  assign bus.InstrOut     = head.instr;
  assign bus.InstrOutAddr = head.addr;

endmodule
